// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: operation codes, result classes, divider states.
package ex_stage_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned ALUSEL_W   = 3;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DIV_ITERS  = REG_W;
    localparam int unsigned CNT_W      = $clog2(DIV_ITERS);

    // Operation codes decoded by ID
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_JAL_OP  = 8'b0101_0000;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    // Result classes decoded by ID
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP         = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [ALUSEL_W-1:0] EXE_RES_JUMP_BRANCH = 3'b110;

    // Divider handshake levels
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // HI/LO pair; HI holds the remainder, LO the quotient
    typedef struct packed {
        logic [REG_W-1:0] hi;
        logic [REG_W-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set
    function automatic logic [REG_W-1:0] cond_neg(input logic [REG_W-1:0] x, input logic neg);
        return neg ? (~x + REG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Sequential restoring divider: one quotient bit per cycle, signed fix-up on completion.
module ex_stage_div_unit
    import ex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [REG_W-1:0] opdata1,
    input  logic [REG_W-1:0] opdata2,
    input  logic             annul,
    output hilo_t            result,
    output logic             ready
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] rem_q, rem_d;
    logic [REG_W-1:0] quo_q, quo_d;
    logic [REG_W-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    hilo_t            result_q, result_d;
    logic             ready_q, ready_d;

    logic [REG_W:0]   partial;
    logic [REG_W:0]   trial;
    logic             fits;
    logic [REG_W-1:0] rem_step;
    logic [REG_W-1:0] quo_step;

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract
    always_comb begin
        partial  = {rem_q, quo_q[REG_W-1]};
        trial    = partial - {1'b0, dvsr_q};
        fits     = ~trial[REG_W];
        rem_step = fits ? trial[REG_W-1:0] : partial[REG_W-1:0];
        quo_step = {quo_q[REG_W-2:0], fits};
    end

    // Divider state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and datapath update; annul returns to idle from any state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            DIV_FREE: begin
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = cond_neg(opdata1, signed_div & opdata1[REG_W-1]);
                        dvsr_d    = cond_neg(opdata2, signed_div & opdata2[REG_W-1]);
                        neg_quo_d = signed_div & (opdata1[REG_W-1] ^ opdata2[REG_W-1]);
                        neg_rem_d = signed_div & opdata1[REG_W-1];
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
            end
            DIV_ON: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    state_d     = DIV_END;
                    result_d.hi = cond_neg(rem_step, neg_rem_q);
                    result_d.lo = cond_neg(quo_step, neg_quo_q);
                end
            end
            DIV_END: begin
                state_d = DIV_FREE;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase

        if (annul) begin
            state_d = DIV_FREE;
        end

        ready_d = (state_d == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO registers, and stall control around the divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      link_addr_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  stallreq_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o
);

    // The result class is implied by the operation code here
    logic unused_alusel;
    assign unused_alusel = ^alusel_i;

    hilo_t            hilo_q;
    hilo_t            div_result;
    logic             div_ready;
    logic             div_op;
    logic             div_signed;
    logic [REG_W-1:0] sum;
    logic             add_ovf;
    logic [REG_W-1:0] alu_data;
    logic             alu_wen;

    assign div_op     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign div_signed = (aluop_i == EXE_DIV_OP);

    ex_stage_div_unit u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_op),
        .signed_div (div_signed),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .annul      (flush_i),
        .result     (div_result),
        .ready      (div_ready)
    );

    // Signed overflow: operands agree in sign but the wrapped sum does not
    always_comb begin
        sum     = reg1_i + reg2_i;
        add_ovf = (reg1_i[REG_W-1] == reg2_i[REG_W-1]) && (sum[REG_W-1] != reg1_i[REG_W-1]);
    end

    // Result mux and per-operation write permission
    always_comb begin
        alu_data = '0;
        alu_wen  = 1'b0;
        unique case (aluop_i)
            EXE_OR_OP: begin
                alu_data = reg1_i | reg2_i;
                alu_wen  = 1'b1;
            end
            EXE_ADD_OP: begin
                alu_data = sum;
                alu_wen  = ~add_ovf;
            end
            EXE_JAL_OP: begin
                alu_data = link_addr_i;
                alu_wen  = 1'b1;
            end
            EXE_MFHI_OP: begin
                alu_data = hilo_q.hi;
                alu_wen  = 1'b1;
            end
            EXE_MFLO_OP: begin
                alu_data = hilo_q.lo;
                alu_wen  = 1'b1;
            end
            default: begin
                alu_data = '0;
                alu_wen  = 1'b0;
            end
        endcase
    end

    // Writeback bundle and stall request, forced quiet during reset
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i & alu_wen & ~flush_i;
            wdata_o    = alu_data;
            stallreq_o = div_op & ~div_ready & ~flush_i;
        end
    end

    // HI/LO commit on the edge that retires a division; flush suppresses it
    always_ff @(posedge clk) begin
        if (!rst) begin
            hilo_q <= '0;
        end else if (div_ready && !flush_i) begin
            hilo_q <= div_result;
        end
    end

    assign hi_o = hilo_q.hi;
    assign lo_o = hilo_q.lo;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] link_addr_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .link_addr_i (link_addr_i),
        .flush_i     (flush_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] sel_for(input logic [7:0] op);
        case (op)
            EXE_OR_OP:                return EXE_RES_LOGIC;
            EXE_ADD_OP:               return EXE_RES_ARITHMETIC;
            EXE_JAL_OP:               return EXE_RES_JUMP_BRANCH;
            EXE_MFHI_OP, EXE_MFLO_OP: return EXE_RES_MOVE;
            default:                  return EXE_RES_NOP;
        endcase
    endfunction

    // Quotient/remainder from plain integer arithmetic; zero divisor yields zeros
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] link, input logic wr,
                           output logic [31:0] data, output logic wen);
        logic [31:0] s32;
        longint      s;
        data = 32'd0;
        wen  = 1'b0;
        case (op)
            EXE_OR_OP:   begin data = a | b; wen = wr; end
            EXE_ADD_OP: begin
                s32  = a + b;
                s    = longint'($signed(a)) + longint'($signed(b));
                data = s32;
                wen  = wr && (s == longint'($signed(s32)));
            end
            EXE_JAL_OP:  begin data = link; wen = wr; end
            EXE_MFHI_OP: begin data = hi_m; wen = wr; end
            EXE_MFLO_OP: begin data = lo_m; wen = wr; end
            default:     begin data = 32'd0; wen = 1'b0; end
        endcase
    endtask

    task automatic run_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] link, input logic [4:0] wd, input logic wr,
                           input logic fl);
        logic [31:0] exp_data;
        logic        exp_wen;
        @(negedge clk);
        aluop_i     = op;
        alusel_i    = sel_for(op);
        reg1_i      = a;
        reg2_i      = b;
        link_addr_i = link;
        wd_i        = wd;
        wreg_i      = wr;
        flush_i     = fl;
        ref_alu(op, a, b, link, wr, exp_data, exp_wen);
        if (fl) exp_wen = 1'b0;
        #1;
        chk($sformatf("wdata op=%02h", op), wdata_o, exp_data);
        chk($sformatf("wreg op=%02h", op), wreg_o, exp_wen);
        chk($sformatf("wd op=%02h", op), wd_o, wd);
        chk($sformatf("stall op=%02h", op), stallreq_o, 0);
        chk("hi_hold", hi_o, hi_m);
        chk("lo_hold", lo_o, lo_m);
    endtask

    // Present a divide and hold it while stalled; optionally flush or reset at cycle index
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input int rst_at);
        int   stalls;
        logic done;
        logic aborted;
        logic [63:0] res;
        stalls  = 0;
        done    = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        aluop_i  = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        alusel_i = EXE_RES_NOP;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'($urandom_range(1, 31));
        wreg_i   = 1'b1;
        flush_i  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == flush_at) begin
                flush_i = 1'b1;
                #1;
                chk("flush_stall", stallreq_o, 0);
                chk("flush_wreg", wreg_o, 0);
                done    = 1'b1;
                aborted = 1'b1;
            end else if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_stall", stallreq_o, 0);
                chk("rst_wreg", wreg_o, 0);
                chk("rst_wd", wd_o, 0);
                chk("rst_wdata", wdata_o, 0);
                done    = 1'b1;
                aborted = 1'b1;
                hi_m    = '0;
                lo_m    = '0;
            end else begin
                chk("div_wreg", wreg_o, 0);
                if (stallreq_o) stalls++;
                else done = 1'b1;
            end
        end
        chk("div_done", done, 1);
        if (!aborted) begin
            chk($sformatf("div_stalls %08h/%08h", a, b), stalls, (b == 32'd0) ? 2 : 33);
            res  = ref_div(sgn, a, b);
            hi_m = res[63:32];
            lo_m = res[31:0];
        end
        @(negedge clk);
        aluop_i = EXE_NOP_OP;
        flush_i = 1'b0;
        rst     = 1'b1;
        #1;
        chk($sformatf("div_hi s=%0d %08h/%08h", sgn, a, b), hi_o, hi_m);
        chk($sformatf("div_lo s=%0d %08h/%08h", sgn, a, b), lo_o, lo_m);
    endtask

    logic [7:0] op_pool [9] = '{EXE_OR_OP, EXE_ADD_OP, EXE_JAL_OP, EXE_MFHI_OP, EXE_MFLO_OP,
                                EXE_NOP_OP, 8'hAA, EXE_DIV_OP, EXE_DIVU_OP};

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b;
        rst         = 1'b0;
        aluop_i     = EXE_OR_OP;
        alusel_i    = EXE_RES_LOGIC;
        reg1_i      = 32'h1234_5678;
        reg2_i      = 32'h0000_00FF;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        link_addr_i = 32'h0000_0100;
        flush_i     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wd", wd_o, 0);
        chk("reset_wreg", wreg_o, 0);
        chk("reset_wdata", wdata_o, 0);
        chk("reset_stall", stallreq_o, 0);
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        @(negedge clk);
        rst = 1'b1;

        run_alu(EXE_OR_OP, 32'h0000_1100, 32'h0000_0011, 32'h0, 5'd5, 1'b1, 1'b0);
        run_alu(EXE_ADD_OP, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd3, 1'b1, 1'b0);
        run_alu(EXE_ADD_OP, 32'h5, 32'h3, 32'h0, 5'd4, 1'b1, 1'b0);
        run_alu(EXE_ADD_OP, 32'h8000_0000, 32'h8000_0000, 32'h0, 5'd4, 1'b1, 1'b0);
        run_alu(EXE_JAL_OP, 32'h0, 32'h0, 32'h0000_0108, 5'd31, 1'b1, 1'b0);
        run_alu(EXE_OR_OP, 32'h1, 32'h2, 32'h0, 5'd9, 1'b1, 1'b1);

        run_div(1'b1, 32'h0000_0005, 32'h0, -1, -1);
        run_div(1'b0, 32'd100, 32'd7, -1, -1);
        run_alu(EXE_MFLO_OP, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        run_alu(EXE_MFHI_OP, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        run_alu(EXE_MFLO_OP, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
        run_div(1'b0, 32'hDEAD_BEEF, 32'd3, 11, -1);
        run_div(1'b1, 32'h1234_5678, 32'hFFFF_FF00, 33, -1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd10, 15, -1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd10, -1, -1);
        run_div(1'b1, 32'h7FFF_0000, 32'd12345, -1, 15);
        run_alu(EXE_MFHI_OP, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = op_pool[$urandom_range(0, 8)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
            if (op == EXE_DIV_OP || op == EXE_DIVU_OP) begin
                if ($urandom_range(0, 7) == 0) b = 32'd0;
                run_div(op == EXE_DIV_OP, a, b, -1, -1);
            end else begin
                run_alu(op, a, b, $urandom, 5'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
